// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state, funct3 encodings and error codes for the MW-stage LSU
package lsu_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_R, ST_DONE} state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_MIS  = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: legality/alignment checks, store lane replication with byte enables, and load extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_a,
  output logic [31:0] rdata_x,
  output logic        illegal,
  output logic        misalign
);
  logic [31:0] sh;
  // size decode drives every lane decision; loads shift the addressed lane down to bit 0 before extending
  always_comb begin
    illegal  = we ? (f3 > F3_W) : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misalign = (f3[1:0] == 2'b01) ? off[0] : (f3[1:0] == 2'b10) ? (off != 2'b00) : 1'b0;
    be       = (f3[1:0] == 2'b00) ? 4'b0001 << off : (f3[1:0] == 2'b01) ? 4'b0011 << off : 4'b1111;
    wdata_a  = (f3[1:0] == 2'b00) ? {4{wdata[7:0]}} : (f3[1:0] == 2'b01) ? {2{wdata[15:0]}} : wdata;
    sh       = rdata >> {off, 3'b000};
    rdata_x  = (f3 == F3_B)  ? {{24{sh[7]}}, sh[7:0]} :
               (f3 == F3_BU) ? {24'd0, sh[7:0]} :
               (f3 == F3_H)  ? {{16{sh[15]}}, sh[15:0]} :
               (f3 == F3_HU) ? {16'd0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu_mw.sv
// lsu_mw: MW-stage load/store unit driving a single-outstanding req/gnt/rvalid bus with timeout
module lsu_mw
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult_MW,
  input  logic [31:0] rdata2_MW,
  output logic        Stall_MW,
  output logic [31:0] load_data,
  output logic [1:0]  lsu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d, err_q, err_d;
  logic [3:0]  a_be;
  logic [31:0] a_wdata, a_rdata;
  logic        a_ill, a_mis, idle, accept, tmo;
  assign idle   = state_q == ST_IDLE;
  assign accept = idle && mem_req && !a_ill && !a_mis;
  assign tmo    = cnt_q == TMO_LAST;
  // in IDLE the aligner checks the incoming request; afterwards it extends read data using the latched access
  lsu_align u_align (
    .we      (idle ? mem_we : we_q),
    .f3      (idle ? funct3 : f3_q),
    .off     (idle ? ALUResult_MW[1:0] : off_q),
    .wdata   (rdata2_MW),
    .rdata   (bus_rdata),
    .be      (a_be),
    .wdata_a (a_wdata),
    .rdata_x (a_rdata),
    .illegal (a_ill),
    .misalign(a_mis)
  );
  assign Stall_MW  = !rst && (accept || state_q == ST_REQ || state_q == ST_WAIT_R);
  assign bus_req   = state_q == ST_REQ;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign load_data = load_q;
  assign lsu_err   = err_q;
  // next-state: accept or reject in IDLE, gnt/rvalid or timeout in bus states, DONE always returns to IDLE
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    load_d  = load_q;
    err_d   = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        err_d = !mem_req ? ERR_NONE : a_ill ? ERR_ILL : a_mis ? ERR_MIS : ERR_NONE;
        if (accept) begin
          state_d = ST_REQ;
          addr_d  = {ALUResult_MW[31:2], 2'b00};
          wdata_d = a_wdata;
          be_d    = a_be;
          we_d    = mem_we;
          f3_d    = funct3;
          off_d   = ALUResult_MW[1:0];
        end
      end
      ST_REQ: begin
        state_d = bus_gnt ? (we_q ? ST_DONE : ST_WAIT_R) : tmo ? ST_DONE : ST_REQ;
        err_d   = (!bus_gnt && tmo) ? ERR_TMO : ERR_NONE;
      end
      ST_WAIT_R: begin
        state_d = (bus_rvalid || tmo) ? ST_DONE : ST_WAIT_R;
        err_d   = (!bus_rvalid && tmo) ? ERR_TMO : ERR_NONE;
        load_d  = bus_rvalid ? a_rdata : load_q;
      end
      default: state_d = ST_IDLE;
    endcase
    cnt_d = (state_d == state_q && (state_q == ST_REQ || state_q == ST_WAIT_R)) ? cnt_q + 16'd1 : 16'd0;
  end
  // state and registered bus/result fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      be_q    <= be_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_lsu_mw.sv
// tb_lsu_mw: randomized and directed LSU traffic checked by a queue-based scoreboard and monitor
module tb_lsu_mw;
  localparam int T = 8;
  logic clk = 0, rst = 1;
  logic mem_req = 0, mem_we = 0, bus_gnt = 0, bus_rvalid = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] ALUResult_MW = 0, rdata2_MW = 0, bus_rdata = 0;
  logic Stall_MW, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [1:0] lsu_err;
  logic [3:0] bus_be;
  int checks = 0, errors = 0;
  bit mon_en = 0, prev_stall = 0;
  logic [31:0] last_load = 0;
  typedef struct {int kind; logic [31:0] a, b, c; logic d;} exp_t;
  exp_t q[$];

  lsu_mw #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
    .ALUResult_MW(ALUResult_MW), .rdata2_MW(rdata2_MW), .Stall_MW(Stall_MW),
    .load_data(load_data), .lsu_err(lsu_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    int unsigned shifted;
    shifted = rd / (32'd1 << (8 * (addr % 4)));
    case (f3)
      3'd0: return (shifted % 256 >= 128) ? shifted % 256 - 256 : shifted % 256;
      3'd4: return shifted % 256;
      3'd1: return (shifted % 65536 >= 32768) ? shifted % 65536 - 65536 : shifted % 65536;
      3'd5: return shifted % 65536;
      default: return rd;
    endcase
  endfunction

  // monitor: pops one expectation per observable DUT event
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) prev_stall = 0;
    else begin
      if (bus_req && bus_gnt) begin
        if (q.size() == 0) chk("unexpected_bus_access", 1, 0);
        else begin
          e = q.pop_front();
          chk("bus_kind", e.kind, 0);
          chk("bus_addr", bus_addr, e.a);
          chk("bus_we", bus_we, e.d);
          if (e.d) begin
            chk("bus_be", bus_be, e.b);
            chk("bus_wdata", bus_wdata, e.c);
          end
        end
      end
      if (prev_stall && !Stall_MW) begin
        if (q.size() == 0) chk("unexpected_stall_release", 1, 0);
        else begin
          e = q.pop_front();
          chk("end_kind", e.kind, 1);
          chk("end_lsu_err", lsu_err, e.a);
          chk("end_load_data", load_data, e.b);
        end
      end else if (lsu_err != 0) begin
        if (q.size() == 0) chk("unexpected_lsu_err", lsu_err, 0);
        else begin
          e = q.pop_front();
          chk("err_kind", e.kind, 2);
          chk("err_code", lsu_err, e.a);
          chk("err_no_stall", Stall_MW, 0);
        end
      end
      prev_stall = Stall_MW;
    end
  end

  // one transaction: g = REQ cycle carrying gnt, r = WAIT_R cycle carrying rvalid (>= T means never)
  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int g, input int r);
    int sz;
    bit legal;
    logic [31:0] repl;
    sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    legal = we ? (f3 <= 2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    @(posedge clk); #1;
    mem_req = 1; mem_we = we; funct3 = f3; ALUResult_MW = addr; rdata2_MW = wd;
    if (!legal || addr % sz != 0) begin
      q.push_back('{2, legal ? 32'd1 : 32'd2, 0, 0, 0});
      @(posedge clk); #1 mem_req = 0;
      repeat (2) @(posedge clk);
      return;
    end
    repl = (sz == 1) ? wd % 256 * 32'h01010101 : (sz == 2) ? wd % 65536 * 32'h00010001 : wd;
    if (g < T) q.push_back('{0, addr - addr % 4, ((32'd1 << sz) - 1) << (addr % 4), repl, we});
    if (g >= T) q.push_back('{1, 3, last_load, 0, 0});
    else if (we) q.push_back('{1, 0, last_load, 0, 0});
    else begin
      if (r < T) last_load = model_load(f3, addr, rd);
      q.push_back('{1, r < T ? 0 : 3, last_load, 0, 0});
    end
    @(posedge clk); #1 mem_req = 0;
    for (int i = 0; i < T; i++) begin
      if (i == g) begin
        bus_gnt = 1;
        bus_rvalid = $urandom_range(0, 1);
        bus_rdata = $urandom;
      end
      @(posedge clk); #1 bus_gnt = 0; bus_rvalid = 0;
      if (i == g) break;
    end
    if (!we && g < T)
      for (int i = 0; i < T; i++) begin
        if (i == r) begin bus_rvalid = 1; bus_rdata = rd; end
        @(posedge clk); #1 bus_rvalid = 0;
        if (i == r) break;
      end
    bus_rvalid = $urandom_range(0, 1);
    bus_rdata = $urandom;
    @(posedge clk); #1 bus_rvalid = 0;
    repeat ($urandom_range(0, 1)) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", Stall_MW, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_lsu_err", lsu_err, 0);
    rst = 0;
    mon_en = 1;
    @(posedge clk); #1;
    mem_req = 1; mem_we = 0; funct3 = 3'd2; ALUResult_MW = 32'h400;
    q.push_back('{0, 32'h400, 0, 0, 0});
    @(posedge clk); #1 mem_req = 0; bus_gnt = 1;
    @(posedge clk); #1 bus_gnt = 0;
    @(posedge clk); #1 mon_en = 0;
    chk("wait_r_stall", Stall_MW, 1);
    rst = 1;
    #1;
    chk("midrst_bus_req", bus_req, 0);
    chk("midrst_stall", Stall_MW, 0);
    @(posedge clk); #1 rst = 0; bus_rvalid = 1; bus_rdata = 32'h12345678;
    @(posedge clk); #1 bus_rvalid = 0;
    chk("midrst_load_data", load_data, 0);
    chk("midrst_bus_req_after", bus_req, 0);
    mon_en = 1;
    do_txn(1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1, 0);
    do_txn(0, 3'd0, 32'h203, 0, 32'h80FFFFFF, 0, 1);
    chk("lb_sign", load_data, 32'hFFFFFF80);
    do_txn(0, 3'd4, 32'h203, 0, 32'h80FFFFFF, 2, 0);
    chk("lbu_zero", load_data, 32'h00000080);
    do_txn(1, 3'd1, 32'h302, 32'h0000ABCD, 0, 0, 0);
    do_txn(0, 3'd2, 32'h101, 0, 0, 0, 0);
    do_txn(0, 3'd2, 32'h500, 0, 32'h55AA55AA, 0, T + 2);
    do_txn(1, 3'd0, 32'h600, 32'h77, 0, T, 0);
    do_txn(0, 3'd2, 32'h700, 0, 32'hCAFEF00D, T - 1, T - 1);
    do_txn(1, 3'd5, 32'h800, 0, 0, 0, 0);
    for (int n = 0; n < 80; n++) begin
      logic [2:0] f3;
      bit we;
      we = $urandom_range(0, 1);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) :
           we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4) == 3 ? 5 : $urandom_range(0, 4));
      do_txn(we, f3, {$urandom_range(0, 1023), 2'b00} + ($urandom_range(0, 2) == 0 ? 32'($urandom_range(0, 3)) : 32'd0),
             $urandom, $urandom, $urandom_range(0, T + 1), $urandom_range(0, T + 1));
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mw.md
LSU_MW -- requirements
Module: lsu_mw

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 256, max cycles waited for bus_gnt or bus_rvalid before abort (range 2..65535).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: mem_req  input  1  MW-stage instruction is a load or store.
REQ-005 SHALL have port: mem_we  input  1  1 = store, 0 = load; valid with mem_req.
REQ-006 SHALL have port: funct3  input  3  access size/sign (RV32I load/store encoding).
REQ-007 SHALL have port: ALUResult_MW  input  32  effective byte address.
REQ-008 SHALL have port: rdata2_MW  input  32  store data, right-aligned.
REQ-009 SHALL have port: Stall_MW  output  1  hold the MW pipeline register.
REQ-010 SHALL have port: load_data  output  32  extended load result.
REQ-011 SHALL have port: lsu_err  output  2  one-cycle error code: 00 none, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-012 SHALL have ports: bus_req output 1, bus_we output 1, bus_addr output 32 (bits[1:0]=0), bus_wdata output 32, bus_be output 4, bus_gnt input 1, bus_rvalid input 1, bus_rdata input 32.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT_R, DONE.
REQ-014 IDLE: mem_req with legal, aligned access SHALL latch word address, be, wdata, we, funct3 and move to REQ; Stall_MW SHALL be 1 combinationally that cycle.
REQ-015 REQ: bus_req=1 with registered bus_* fields held stable until bus_gnt; on gnt store -> DONE, load -> WAIT_R.
REQ-016 WAIT_R: bus_req=0; on bus_rvalid capture extended bus_rdata into load_data -> DONE.
REQ-017 DONE: Stall_MW=0, bus_req=0; unconditional -> IDLE (no back-to-back request accepted in DONE).
REQ-018 Stall_MW SHALL be 1 in REQ and WAIT_R, 0 in DONE and in IDLE without a legal mem_req.
REQ-019 bus_rvalid SHALL be ignored outside WAIT_R, including a cycle where it coincides with bus_gnt in REQ.
REQ-020 Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no bus access, no stall, lsu_err=01 for one cycle, stay IDLE.
REQ-021 Illegal funct3 (loads 011/110/111, stores 011-111): no access, no stall, lsu_err=10 one cycle.
REQ-022 Stores: SB replicates byte to all lanes, be=0001<<addr[1:0]; SH replicates half, be=0011<<addr[1:0]; SW be=1111.
REQ-023 Loads: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-024 Timeout counter SHALL clear on entering REQ and WAIT_R, increment each cycle there; at TIMEOUT_CYCLES-1 without event -> DONE, lsu_err=11 one cycle, load_data unchanged.
REQ-025 load_data SHALL hold its value until the next completed load.

Reset
REQ-026 rst SHALL asynchronously force IDLE, Stall_MW=0, bus_req=0, bus_we=0, bus_addr/bus_wdata/load_data=0, bus_be=0, lsu_err=00, counter=0.
REQ-027 Reset during REQ or WAIT_R SHALL drop bus_req immediately; a later bus_rvalid SHALL be ignored.

Structure
REQ-028 lsu_pkg SHALL hold state enum, funct3 constants, lsu_err codes.
REQ-029 Lane/byte-enable generation and load extension SHALL be a combinational sub-module lsu_align, instantiated once.

Verification
REQ-030 SW addr 0x100 data 0xDEADBEEF, gnt on 2nd REQ cycle -> be=1111, bus_addr=0x100, Stall_MW high 3 cycles then low.
REQ-031 LB addr 0x203, bus_rdata 0x80FF_FFFF -> load_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SH addr 0x302 data 0x0000ABCD -> bus_wdata=0xABCDABCD, be=1100.
REQ-033 LW addr 0x101 -> lsu_err=01 one cycle, bus_req never asserted, Stall_MW=0.
REQ-034 Load with gnt but no rvalid, TIMEOUT_CYCLES=8 -> lsu_err=11 after 8 WAIT_R cycles, Stall_MW released.
REQ-035 rst asserted mid-WAIT_R -> bus_req=0 and Stall_MW=0 same cycle; subsequent rvalid leaves load_data=0.
